// File: rtl/counter_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : counter_write_arbiter
// Brief    : Two-client ownership arbiter that gates write strobes to the
//            shared 9-bit counter, with bounded-hold preemption.
// Revision : 1.0 - initial release
// ============================================================================
module counter_write_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int HCW      = 5
) (
    input  logic clk,
    input  logic nrst,
    input  logic req1,
    input  logic req2,
    input  logic wr1_in,
    input  logic wr2_in,
    output logic gnt1,
    output logic gnt2,
    output logic wr1,
    output logic wr2,
    output logic err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN1 = 2'd1,
        OWN2 = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [HCW-1:0] c_hold_lim  = (MAX_HOLD == 0) ? '0 : HCW'(MAX_HOLD - 1);
    localparam logic [HCW-1:0] c_hold_max  = '1;
    localparam bit             c_preempt_en = (MAX_HOLD != 0);

    state_t          r_state;
    logic [HCW-1:0]  r_hold_cnt;
    logic            r_last2;
    logic            r_err;

    logic            w_own_req;
    logic            w_other_req;
    logic            w_preempt;
    state_t          w_pick;

    assign gnt1 = (r_state == OWN1);
    assign gnt2 = (r_state == OWN2);
    assign wr1  = wr1_in & gnt1;
    assign wr2  = wr2_in & gnt2;
    assign err  = r_err;

    assign w_own_req   = (r_state == OWN1) ? req1 : req2;
    assign w_other_req = (r_state == OWN1) ? req2 : req1;
    assign w_preempt   = c_preempt_en && (r_hold_cnt >= c_hold_lim) && w_other_req;

    // Tie goes to whichever client did not own last.
    always_comb begin
        w_pick = IDLE;
        if (req1 && req2) begin
            w_pick = r_last2 ? OWN1 : OWN2;
        end else if (req1) begin
            w_pick = OWN1;
        end else if (req2) begin
            w_pick = OWN2;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_last2    <= 1'b1;
            r_err      <= 1'b0;
        end else begin
            r_err <= (wr1_in & ~gnt1) | (wr2_in & ~gnt2);
            case (r_state)
                IDLE, GAP: begin
                    r_state <= w_pick;
                    if (w_pick == OWN1) begin
                        r_last2    <= 1'b0;
                        r_hold_cnt <= '0;
                    end else if (w_pick == OWN2) begin
                        r_last2    <= 1'b1;
                        r_hold_cnt <= '0;
                    end
                end
                OWN1, OWN2: begin
                    if (!w_own_req || w_preempt) begin
                        r_state <= GAP;
                    end else if (r_hold_cnt != c_hold_max) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_write_arbiter
// Brief    : Self-checking bench: three arbiter configurations against a
//            behavioural ownership model, directed plus random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_write_arbiter;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic req1 = 1'b1;
    logic req2 = 1'b1;
    logic wr1_in = 1'b0;
    logic wr2_in = 1'b0;
    logic [2:0] gnt1, gnt2, wr1, wr2, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance 0: default; 1: short hold with narrow counter; 2: no preemption.
    counter_write_arbiter u_dut0 (
        .clk(clk), .nrst(nrst), .req1(req1), .req2(req2), .wr1_in(wr1_in), .wr2_in(wr2_in),
        .gnt1(gnt1[0]), .gnt2(gnt2[0]), .wr1(wr1[0]), .wr2(wr2[0]), .err(err[0])
    );
    counter_write_arbiter #(.MAX_HOLD(4), .HCW(3)) u_dut1 (
        .clk(clk), .nrst(nrst), .req1(req1), .req2(req2), .wr1_in(wr1_in), .wr2_in(wr2_in),
        .gnt1(gnt1[1]), .gnt2(gnt2[1]), .wr1(wr1[1]), .wr2(wr2[1]), .err(err[1])
    );
    counter_write_arbiter #(.MAX_HOLD(0), .HCW(5)) u_dut2 (
        .clk(clk), .nrst(nrst), .req1(req1), .req2(req2), .wr1_in(wr1_in), .wr2_in(wr2_in),
        .gnt1(gnt1[2]), .gnt2(gnt2[2]), .wr1(wr1[2]), .wr2(wr2[2]), .err(err[2])
    );

    // Behavioural model: owner 0 means nobody (idle or turnaround look alike outside).
    int maxh[3] = '{16, 4, 0};
    int sat[3]  = '{31, 7, 31};
    int m_owner[3] = '{0, 0, 0};
    int m_held[3]  = '{0, 0, 0};
    int m_last[3]  = '{2, 2, 2};
    bit m_err[3]   = '{0, 0, 0};

    always @(posedge clk or negedge nrst) begin
        for (int i = 0; i < 3; i++) begin
            if (!nrst) begin
                m_owner[i] = 0; m_held[i] = 0; m_last[i] = 2; m_err[i] = 0;
            end else begin
                int winner;
                bit mine, other;
                m_err[i] = (wr1_in && m_owner[i] != 1) || (wr2_in && m_owner[i] != 2);
                if (m_owner[i] != 0) begin
                    mine  = (m_owner[i] == 1) ? req1 : req2;
                    other = (m_owner[i] == 1) ? req2 : req1;
                    if (!mine || (maxh[i] != 0 && m_held[i] >= maxh[i] - 1 && other))
                        m_owner[i] = 0;
                    else if (m_held[i] < sat[i])
                        m_held[i] = m_held[i] + 1;
                end else begin
                    if (req1 && req2) winner = (m_last[i] == 1) ? 2 : 1;
                    else if (req1)    winner = 1;
                    else if (req2)    winner = 2;
                    else              winner = 0;
                    if (winner != 0) begin
                        m_owner[i] = winner; m_last[i] = winner; m_held[i] = 0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %b expected %b", name, idx, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check("gnt1", i, gnt1[i], m_owner[i] == 1);
            check("gnt2", i, gnt2[i], m_owner[i] == 2);
            check("wr1",  i, wr1[i],  wr1_in && m_owner[i] == 1);
            check("wr2",  i, wr2[i],  wr2_in && m_owner[i] == 2);
            check("err",  i, err[i],  m_err[i]);
        end
    endtask

    task automatic tick(input logic r1, input logic r2, input logic w1, input logic w2);
        @(negedge clk);
        req1 = r1; req2 = r2; wr1_in = w1; wr2_in = w2;
        #1;
        compare_all();
    endtask

    initial begin
        // Reset held with both requesting: everything stays low.
        for (int k = 0; k < 3; k++) begin
            tick(1, 1, 0, 0);
            for (int i = 0; i < 3; i++) check("rst_gnt1_lit", i, gnt1[i], 1'b0);
        end
        nrst = 1'b1;

        // Both held: tie to client 1, then preemption pattern / unbounded hold.
        for (int c = 0; c < 25; c++) begin
            tick(1, 1, 0, c == 1);
            check("pre_gnt1_lit", 1, gnt1[1], (c % 10) < 4);
            check("pre_gnt2_lit", 1, gnt2[1], (c % 10) >= 5 && (c % 10) < 9);
            check("hold16_gnt1_lit", 0, gnt1[0], c < 16);
            check("nopre_gnt1_lit", 2, gnt1[2], 1'b1);
            if (c == 1) check("viol_wr2_lit", 1, wr2[1], 1'b0);
            if (c == 2) check("viol_err_lit", 1, err[1], 1'b1);
            if (c == 3) check("viol_err_clr_lit", 1, err[1], 1'b0);
        end

        // Client 1 releases: every instance ends up owned by client 2.
        for (int d = 0; d < 4; d++) tick(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) check("handover_gnt2_lit", i, gnt2[i], 1'b1);

        // Asynchronous reset mid-ownership drops grants before the next edge.
        @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        compare_all();
        for (int i = 0; i < 3; i++) check("async_gnt2_lit", i, gnt2[i], 1'b0);
        tick(1, 1, 0, 0);
        nrst = 1'b1;
        tick(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) check("post_rst_gnt1_lit", i, gnt1[i], 1'b1);

        // Randomised traffic with sticky requests and occasional reset pulses.
        for (int n = 0; n < 3000; n++) begin
            logic r1, r2;
            r1 = ($urandom_range(0, 7) == 0) ? ~req1 : req1;
            r2 = ($urandom_range(0, 7) == 0) ? ~req2 : req2;
            tick(r1, r2, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #1 nrst = 1'b0;
                #1;
                compare_all();
                #1 nrst = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_write_arbiter.md
Name: counter_write_arbiter

Overview:
Arbitrates write access for the two writers of the shared 9-bit counter. Each writer requests ownership, waits for a grant, then writes through this block. The block gates the write enables so that only the owner's write reaches the counter, which makes the bitwise-OR collision case impossible. It sits between the two writer processes and the counter's wr1/wr2 inputs; data buses bypass it.

Parameters:
MAX_HOLD, 16, cycles an owner may hold the grant while the other client waits before forced release; 0 disables preemption.
HCW, 5, width of the hold counter; must satisfy 2^HCW > MAX_HOLD.

Ports:
clk  input  1  system clock, all state changes on rising edge.
nrst  input  1  asynchronous active-low reset.
req1  input  1  client 1 requests ownership; level, held until done.
req2  input  1  client 2 requests ownership; level, held until done.
wr1_in  input  1  client 1 raw write strobe.
wr2_in  input  1  client 2 raw write strobe.
gnt1  output  1  registered; client 1 owns the counter.
gnt2  output  1  registered; client 2 owns the counter.
wr1  output  1  gated strobe to counter = wr1_in & gnt1 (combinational from registered gnt1).
wr2  output  1  gated strobe to counter = wr2_in & gnt2.
err  output  1  registered one-cycle pulse: a write strobe was asserted without grant.

Behaviour:
- Reset: asynchronous on nrst low. Reset values: state=IDLE, gnt1=0, gnt2=0, err=0, hold_cnt=0, last=2 (client 1 wins the first tie). Outputs stay low while nrst is low. Deassertion takes effect at the next rising edge.
- States: IDLE, OWN1, OWN2, GAP. gnt1 = (state==OWN1) and gnt2 = (state==OWN2), both decoded from the state register.
- Arbitration (evaluated in IDLE and GAP):
  - req1&~req2 -> OWN1.
  - req2&~req1 -> OWN2.
  - both -> the client != last.
  - neither -> IDLE.
- On entry to OWNx: last<=x, hold_cnt<=0. Latency: req rises before edge k -> gnt high after edge k (1 cycle).
- OWNx:
  - hold_cnt increments each cycle, saturating at 2^HCW-1.
  - Leave to GAP at the next edge if reqx==0.
  - Also leave to GAP if MAX_HOLD!=0, hold_cnt>=MAX_HOLD-1, and the other req==1 (preemption). The preempted client sees gntx drop. It must not assume its writes land afterwards; wr gating enforces this.
  - Otherwise stay. With no competitor, ownership is unbounded.
- GAP: exactly one cycle with both grants low (turnaround), then arbitrate as IDLE.
  - Release-to-other-grant is therefore 2 edges: reqx low at edge k -> GAP after k -> other gnt after k+1.
  - A client re-raising req in GAP while the other client also requests loses the tie (last==x).
- Mutual exclusion: gnt1&gnt2 never both 1; wr1&wr2 never both 1 in any cycle.
- err <= (wr1_in&~gnt1)|(wr2_in&~gnt2) each cycle: one-cycle pulse, 1-cycle latency, no sticky state. The blocked strobe is dropped, never queued.
- Simultaneous req drop and preemption condition: go to GAP (same result).
- Reset mid-ownership: grants drop immediately (asynchronously); last returns to 2.
- HCW saturation: hold_cnt never wraps to 0.

Test Plan:
1. Reset: hold nrst low for 3 cycles with req1=req2=1 -> gnt1=gnt2=wr1=wr2=err=0; release -> gnt1=1 after the first edge (last=2 tie-break).
2. Single client: req2=1 at edge 5 -> gnt2=1 after edge 5. wr2_in pulses pass to wr2 same cycle. req2=0 at edge 9 -> gnt2=0 after 9, state GAP, then IDLE.
3. Handover: client1 owns, req2=1 waiting, req1 drops before edge 20 -> gnt1=0 after 20, gnt2=1 after 21, never both high.
4. Preemption with MAX_HOLD=4: req1 and req2 both held from reset -> gnt1 high 4 cycles, 1 GAP cycle, gnt2 high 4 cycles, alternating indefinitely. With MAX_HOLD=0 -> gnt1 held forever.
5. Violation: wr2_in=1 while gnt1=1 -> wr2=0 in that cycle, err=1 for exactly the next cycle, and the counter sees no write from client 2.
6. Async reset mid-OWN2: pulse nrst low between edges -> gnt2 falls before the next edge. After release with both requesting -> client 1 is granted.
